// File: rtl/pipelined_control.sv
// rtl/pipelined_control.sv - ID-stage decoder with registered ID/EX control word, load-use stall, JR forwarding select and flush FSM
// Optional build macro HAZARD_STATS_EN adds saturating stall_count/flush_count outputs.
module pipelined_control #(
  parameter int REG_ADDR_W   = 5,
  parameter int ALUOP_W      = 4,
  parameter int FLUSH_CYCLES = 1,
  parameter int LINK_REG     = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  branch_taken,
  output logic                  stall,
  output logic                  flush,
  output logic                  ex_valid,
  output logic [REG_ADDR_W-1:0] ex_dest,
  output logic                  ex_RegWrite,
  output logic                  ex_MemToReg,
  output logic                  ex_MemRead,
  output logic                  ex_MemWrite,
  output logic                  ex_Branch,
  output logic                  ex_RegDst,
  output logic                  ex_ALUSrc,
  output logic                  ex_J_Jump,
  output logic [ALUOP_W-1:0]    ex_ALUOp,
  output logic [1:0]            ex_Jump,
  output logic [2:0]            ex_Branch_op
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]           stall_count,
  output logic [31:0]           flush_count
`endif
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BGEZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;

  localparam logic [2:0]            FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam logic [REG_ADDR_W-1:0] LINK_ADDR  = REG_ADDR_W'(LINK_REG);

  typedef enum logic [0:0] {ST_RUN, ST_FLUSH} state_t;

  state_t r_state;
  logic [2:0] r_cnt;

  logic                  w_reg_write;
  logic                  w_mem_to_reg;
  logic                  w_mem_read;
  logic                  w_mem_write;
  logic                  w_branch;
  logic                  w_reg_dst;
  logic                  w_alu_src;
  logic                  w_j_jump;
  logic                  w_is_jal;
  logic                  w_reads_rt;
  logic [3:0]            w_aluop;
  logic [1:0]            w_jump;
  logic [2:0]            w_branch_op;
  logic [REG_ADDR_W-1:0] w_dest;
  logic                  w_jr_fwd;
  logic                  w_stall;
  logic                  w_take;
  logic                  w_jump_in_ex;

  // jr can take its target from the ALU result of the instruction now in EX
  // when that instruction writes rs and is not a load
  assign w_jr_fwd = ex_valid && ex_RegWrite && !ex_MemRead &&
                    (rs != '0) && (ex_dest == rs);

  // Decode the IF/ID fields into the control word
  always_comb begin
    w_reg_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_branch     = 1'b0;
    w_reg_dst    = 1'b0;
    w_alu_src    = 1'b0;
    w_j_jump     = 1'b0;
    w_is_jal     = 1'b0;
    w_reads_rt   = 1'b0;
    w_aluop      = 4'b0000;
    w_jump       = 2'b00;
    w_branch_op  = 3'b000;
    case (opcode)
      OP_RTYPE: begin
        w_reads_rt = 1'b1;
        case (funct)
          F_ADD:   begin w_reg_write = 1'b1; w_aluop = 4'b0001; end
          F_ADDU:  begin w_reg_write = 1'b1; w_aluop = 4'b1010; end
          F_SUB:   begin w_reg_write = 1'b1; w_aluop = 4'b0010; end
          F_SUBU:  begin w_reg_write = 1'b1; w_aluop = 4'b1011; end
          F_AND:   begin w_reg_write = 1'b1; w_aluop = 4'b0011; end
          F_OR:    begin w_reg_write = 1'b1; w_aluop = 4'b0100; end
          F_NOR:   begin w_reg_write = 1'b1; w_aluop = 4'b0101; end
          F_SLT:   begin w_reg_write = 1'b1; w_aluop = 4'b0110; end
          F_SLL:   begin w_reg_write = 1'b1; w_aluop = 4'b0111; end
          F_SRL:   begin w_reg_write = 1'b1; w_aluop = 4'b1000; end
          F_SRA:   begin w_reg_write = 1'b1; w_aluop = 4'b1001; end
          F_JR:    w_jump = w_jr_fwd ? 2'b10 : 2'b01;
          default: ;
        endcase
      end
      OP_ADDI:  begin w_alu_src = 1'b1; w_reg_write = 1'b1; w_reg_dst = 1'b1; w_aluop = 4'b0001; end
      OP_ADDIU: begin w_alu_src = 1'b1; w_reg_write = 1'b1; w_reg_dst = 1'b1; w_aluop = 4'b1010; end
      OP_SLTI:  begin w_alu_src = 1'b1; w_reg_write = 1'b1; w_reg_dst = 1'b1; w_aluop = 4'b0110; end
      OP_ANDI:  begin w_alu_src = 1'b1; w_reg_write = 1'b1; w_reg_dst = 1'b1; w_aluop = 4'b0011; end
      OP_ORI:   begin w_alu_src = 1'b1; w_reg_write = 1'b1; w_reg_dst = 1'b1; w_aluop = 4'b0100; end
      OP_LUI:   begin w_alu_src = 1'b1; w_reg_write = 1'b1; w_reg_dst = 1'b1; w_aluop = 4'b1111; end
      OP_LW: begin
        w_alu_src    = 1'b1;
        w_reg_write  = 1'b1;
        w_reg_dst    = 1'b1;
        w_mem_read   = 1'b1;
        w_mem_to_reg = 1'b1;
        w_aluop      = 4'b0001;
      end
      OP_SW: begin
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
        w_reads_rt  = 1'b1;
        w_aluop     = 4'b0001;
      end
      OP_BEQ:  begin w_branch = 1'b1; w_branch_op = 3'b001; w_reads_rt = 1'b1; end
      OP_BNE:  begin w_branch = 1'b1; w_branch_op = 3'b010; w_reads_rt = 1'b1; end
      OP_BGTZ: begin w_branch = 1'b1; w_branch_op = 3'b011; end
      OP_BGEZ: begin w_branch = 1'b1; w_branch_op = 3'b100; end
      OP_J:    w_j_jump = 1'b1;
      OP_JAL: begin
        w_j_jump    = 1'b1;
        w_jump      = 2'b11;
        w_reg_write = 1'b1;
        w_is_jal    = 1'b1;
      end
      default: ;
    endcase
  end

  // Resolve the write register; non-writing instructions carry register 0
  always_comb begin
    w_dest = '0;
    if (w_reg_write) begin
      if (w_is_jal)       w_dest = LINK_ADDR;
      else if (w_reg_dst) w_dest = rt;
      else                w_dest = rd;
    end
  end

  // Load in EX whose result a dependent instruction in ID needs: hold one cycle
  assign w_stall = (r_state == ST_RUN) && id_valid && ex_valid && ex_MemRead &&
                   (ex_dest != '0) &&
                   ((ex_dest == rs) || (w_reads_rt && (ex_dest == rt)));
  assign stall = w_stall;

  // ID/EX takes the decoded word only in RUN with a live, non-stalled instruction
  assign w_take = !branch_taken && (r_state == ST_RUN) && id_valid && !w_stall;

  // A j/jal sitting in EX keeps its delay-slot instruction, then starts the flush
  assign w_jump_in_ex = ex_valid && ex_J_Jump;

  // ID/EX pipeline register and RUN/FLUSH sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_cnt        <= 3'd0;
      flush        <= 1'b0;
      ex_valid     <= 1'b0;
      ex_dest      <= '0;
      ex_RegWrite  <= 1'b0;
      ex_MemToReg  <= 1'b0;
      ex_MemRead   <= 1'b0;
      ex_MemWrite  <= 1'b0;
      ex_Branch    <= 1'b0;
      ex_RegDst    <= 1'b0;
      ex_ALUSrc    <= 1'b0;
      ex_J_Jump    <= 1'b0;
      ex_ALUOp     <= '0;
      ex_Jump      <= 2'b00;
      ex_Branch_op <= 3'b000;
    end else begin
      ex_valid     <= w_take;
      ex_dest      <= w_take ? w_dest : '0;
      ex_RegWrite  <= w_take & w_reg_write;
      ex_MemToReg  <= w_take & w_mem_to_reg;
      ex_MemRead   <= w_take & w_mem_read;
      ex_MemWrite  <= w_take & w_mem_write;
      ex_Branch    <= w_take & w_branch;
      ex_RegDst    <= w_take & w_reg_dst;
      ex_ALUSrc    <= w_take & w_alu_src;
      ex_J_Jump    <= w_take & w_j_jump;
      ex_ALUOp     <= w_take ? ALUOP_W'(w_aluop) : '0;
      ex_Jump      <= w_take ? w_jump : 2'b00;
      ex_Branch_op <= w_take ? w_branch_op : 3'b000;

      if (branch_taken) begin
        r_state <= ST_FLUSH;
        r_cnt   <= FLUSH_LOAD;
        flush   <= 1'b1;
      end else if (r_state == ST_FLUSH) begin
        if (r_cnt <= 3'd1) begin
          r_state <= ST_RUN;
          r_cnt   <= 3'd0;
          flush   <= 1'b0;
        end else begin
          r_cnt <= r_cnt - 3'd1;
        end
      end else if (w_jump_in_ex) begin
        r_state <= ST_FLUSH;
        r_cnt   <= FLUSH_LOAD;
        flush   <= 1'b1;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating counts of stall cycles and bubbles inserted while flushing
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= 32'd0;
      flush_count <= 32'd0;
    end else begin
      if (w_stall && (stall_count != 32'hFFFF_FFFF))
        stall_count <= stall_count + 32'd1;
      if ((r_state == ST_FLUSH) && (flush_count != 32'hFFFF_FFFF))
        flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_control.sv
// tb/tb_pipelined_control.sv - directed-vector bench for pipelined_control (FLUSH_CYCLES=2)
module tb_pipelined_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rs, rt, rd;
  logic       branch_taken;
  logic       stall, flush, ex_valid;
  logic [4:0] ex_dest;
  logic       ex_RegWrite, ex_MemToReg, ex_MemRead, ex_MemWrite;
  logic       ex_Branch, ex_RegDst, ex_ALUSrc, ex_J_Jump;
  logic [3:0] ex_ALUOp;
  logic [1:0] ex_Jump;
  logic [2:0] ex_Branch_op;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count, flush_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  pipelined_control #(
    .REG_ADDR_W(5), .ALUOP_W(4), .FLUSH_CYCLES(2), .LINK_REG(31)
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .opcode(opcode), .funct(funct),
    .rs(rs), .rt(rt), .rd(rd), .branch_taken(branch_taken),
    .stall(stall), .flush(flush), .ex_valid(ex_valid), .ex_dest(ex_dest),
    .ex_RegWrite(ex_RegWrite), .ex_MemToReg(ex_MemToReg), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_Branch(ex_Branch), .ex_RegDst(ex_RegDst),
    .ex_ALUSrc(ex_ALUSrc), .ex_J_Jump(ex_J_Jump), .ex_ALUOp(ex_ALUOp),
    .ex_Jump(ex_Jump), .ex_Branch_op(ex_Branch_op)
`ifdef HAZARD_STATS_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    id_valid = v; opcode = op; funct = fn; rs = s; rt = t; rd = d;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; branch_taken = 1'b0;
    set_id(1'b1, 6'b000000, 6'b100000, 5'd1, 5'd2, 5'd3);
    tick(); tick();
    n_vec++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL reset_ex_valid got %0h want 0", ex_valid); end
    n_vec++; if (ex_RegWrite !== 1'b0) begin n_err++; $display("FAIL reset_regwrite got %0h want 0", ex_RegWrite); end
    n_vec++; if (ex_ALUOp !== 4'h0) begin n_err++; $display("FAIL reset_aluop got %0h want 0", ex_ALUOp); end
    n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL reset_flush got %0h want 0", flush); end
    reset = 1'b0;
  endtask

  task automatic test_decode();
    set_id(1'b1, 6'b000000, 6'b100000, 5'd1, 5'd2, 5'd3);
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL add_stall got %0h want 0", stall); end
    tick();
    n_vec++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL add_valid got %0h want 1", ex_valid); end
    n_vec++; if (ex_RegWrite !== 1'b1) begin n_err++; $display("FAIL add_regwrite got %0h want 1", ex_RegWrite); end
    n_vec++; if (ex_ALUOp !== 4'b0001) begin n_err++; $display("FAIL add_aluop got %0h want 1", ex_ALUOp); end
    n_vec++; if (ex_dest !== 5'd3) begin n_err++; $display("FAIL add_dest got %0d want 3", ex_dest); end
    set_id(1'b1, 6'b000000, 6'b100010, 5'd1, 5'd2, 5'd4);
    tick();
    n_vec++; if (ex_ALUOp !== 4'b0010) begin n_err++; $display("FAIL sub_aluop got %0h want 2", ex_ALUOp); end
    n_vec++; if (ex_dest !== 5'd4) begin n_err++; $display("FAIL sub_dest got %0d want 4", ex_dest); end
    set_id(1'b1, 6'b000000, 6'b000011, 5'd0, 5'd2, 5'd5);
    tick();
    n_vec++; if (ex_ALUOp !== 4'b1001) begin n_err++; $display("FAIL sra_aluop got %0h want 9", ex_ALUOp); end
    set_id(1'b1, 6'b001111, 6'b000000, 5'd0, 5'd12, 5'd0);
    tick();
    n_vec++; if ({ex_ALUOp, ex_ALUSrc, ex_RegDst, ex_dest} !== {4'b1111, 1'b1, 1'b1, 5'd12}) begin n_err++; $display("FAIL lui_word got %0h/%0h/%0h/%0d want f/1/1/12", ex_ALUOp, ex_ALUSrc, ex_RegDst, ex_dest); end
    set_id(1'b1, 6'b000000, 6'b111111, 5'd1, 5'd2, 5'd6);
    tick();
    n_vec++; if ({ex_valid, ex_RegWrite, ex_ALUOp, ex_dest} !== {1'b1, 1'b0, 4'h0, 5'd0}) begin n_err++; $display("FAIL unknown_funct got v%0h w%0h op%0h d%0d want v1 w0 op0 d0", ex_valid, ex_RegWrite, ex_ALUOp, ex_dest); end
    set_id(1'b1, 6'b000100, 6'b000000, 5'd1, 5'd2, 5'd0);
    tick();
    n_vec++; if ({ex_Branch, ex_Branch_op, ex_RegWrite} !== {1'b1, 3'b001, 1'b0}) begin n_err++; $display("FAIL beq_word got b%0h op%0h w%0h want b1 op1 w0", ex_Branch, ex_Branch_op, ex_RegWrite); end
    set_id(1'b1, 6'b000010, 6'b000000, 5'd0, 5'd0, 5'd0);
    tick();
    n_vec++; if ({ex_J_Jump, ex_Jump, ex_dest} !== {1'b1, 2'b00, 5'd0}) begin n_err++; $display("FAIL j_word got jj%0h j%0h d%0d want jj1 j0 d0", ex_J_Jump, ex_Jump, ex_dest); end
    set_id(1'b0, 6'b000000, 6'b100000, 5'd1, 5'd2, 5'd3);
    tick(); tick(); tick();
    n_vec++; if ({ex_valid, ex_RegWrite} !== 2'b00) begin n_err++; $display("FAIL idle_bubble got %0h want 0", {ex_valid, ex_RegWrite}); end
  endtask

  task automatic test_load_use();
    set_id(1'b1, 6'b100011, 6'b000000, 5'd1, 5'd5, 5'd0);
    tick();
    n_vec++; if ({ex_MemRead, ex_MemToReg, ex_ALUSrc, ex_dest} !== {3'b111, 5'd5}) begin n_err++; $display("FAIL lw_word got %0h want %0h", {ex_MemRead, ex_MemToReg, ex_ALUSrc, ex_dest}, {3'b111, 5'd5}); end
    set_id(1'b1, 6'b000000, 6'b100000, 5'd5, 5'd2, 5'd6);
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL lu_rs_stall got %0h want 1", stall); end
    tick();
    n_vec++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL lu_bubble got %0h want 0", ex_valid); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_stall_release got %0h want 0", stall); end
    tick();
    n_vec++; if ({ex_valid, ex_dest} !== {1'b1, 5'd6}) begin n_err++; $display("FAIL lu_add_latched got v%0h d%0d want v1 d6", ex_valid, ex_dest); end
    set_id(1'b1, 6'b100011, 6'b000000, 5'd1, 5'd7, 5'd0);
    tick();
    set_id(1'b1, 6'b101011, 6'b000000, 5'd1, 5'd7, 5'd0);
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL lu_sw_rt_stall got %0h want 1", stall); end
    tick(); tick();
    n_vec++; if ({ex_valid, ex_MemWrite, ex_dest} !== {2'b11, 5'd0}) begin n_err++; $display("FAIL sw_latched got %0h want %0h", {ex_valid, ex_MemWrite, ex_dest}, {2'b11, 5'd0}); end
    set_id(1'b1, 6'b100011, 6'b000000, 5'd1, 5'd7, 5'd0);
    tick();
    set_id(1'b1, 6'b001000, 6'b000000, 5'd1, 5'd7, 5'd0);
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_addi_rt_nostall got %0h want 0", stall); end
    set_id(1'b1, 6'b100011, 6'b000000, 5'd1, 5'd0, 5'd0);
    tick();
    set_id(1'b1, 6'b000000, 6'b100000, 5'd0, 5'd0, 5'd9);
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_r0_nostall got %0h want 0", stall); end
    tick();
    n_vec++; if ({ex_valid, ex_dest} !== {1'b1, 5'd9}) begin n_err++; $display("FAIL r0_add_latched got v%0h d%0d want v1 d9", ex_valid, ex_dest); end
  endtask

  task automatic test_jr_forward();
    set_id(1'b1, 6'b001000, 6'b000000, 5'd0, 5'd8, 5'd0);
    tick();
    n_vec++; if ({ex_dest, ex_ALUOp, ex_ALUSrc} !== {5'd8, 4'b0001, 1'b1}) begin n_err++; $display("FAIL addi_word got %0h want %0h", {ex_dest, ex_ALUOp, ex_ALUSrc}, {5'd8, 4'b0001, 1'b1}); end
    set_id(1'b1, 6'b000000, 6'b001000, 5'd8, 5'd0, 5'd0);
    tick();
    n_vec++; if ({ex_Jump, ex_RegWrite, ex_dest} !== {2'b10, 1'b0, 5'd0}) begin n_err++; $display("FAIL jr_fwd got j%0h w%0h d%0d want j2 w0 d0", ex_Jump, ex_RegWrite, ex_dest); end
    set_id(1'b1, 6'b001000, 6'b000000, 5'd0, 5'd8, 5'd0);
    tick();
    set_id(1'b1, 6'b000000, 6'b001000, 5'd9, 5'd0, 5'd0);
    tick();
    n_vec++; if (ex_Jump !== 2'b01) begin n_err++; $display("FAIL jr_plain got %0h want 1", ex_Jump); end
  endtask

  task automatic test_branch_flush();
    set_id(1'b1, 6'b000000, 6'b100000, 5'd1, 5'd2, 5'd3);
    branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    n_vec++; if ({flush, ex_valid} !== 2'b10) begin n_err++; $display("FAIL bt_e0 got f%0h v%0h want f1 v0", flush, ex_valid); end
    tick();
    n_vec++; if ({flush, ex_valid, stall} !== 3'b100) begin n_err++; $display("FAIL bt_e1 got %0h want 4", {flush, ex_valid, stall}); end
    tick();
    n_vec++; if ({flush, ex_valid} !== 2'b00) begin n_err++; $display("FAIL bt_e2 got f%0h v%0h want f0 v0", flush, ex_valid); end
    tick();
    n_vec++; if ({ex_valid, ex_dest} !== {1'b1, 5'd3}) begin n_err++; $display("FAIL bt_resume got v%0h d%0d want v1 d3", ex_valid, ex_dest); end
    branch_taken = 1'b1;
    tick(); tick();
    branch_taken = 1'b0;
    n_vec++; if (flush !== 1'b1) begin n_err++; $display("FAIL bt_reload_e1 got %0h want 1", flush); end
    tick();
    n_vec++; if ({flush, ex_valid} !== 2'b10) begin n_err++; $display("FAIL bt_reload_e2 got f%0h v%0h want f1 v0", flush, ex_valid); end
    tick();
    n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL bt_reload_e3 got %0h want 0", flush); end
    tick();
    n_vec++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL bt_reload_resume got %0h want 1", ex_valid); end
  endtask

  task automatic test_jal_and_reset();
    set_id(1'b1, 6'b000011, 6'b000000, 5'd0, 5'd0, 5'd0);
    tick();
    n_vec++; if ({ex_valid, ex_Jump, ex_J_Jump, ex_RegWrite, ex_dest} !== {1'b1, 2'b11, 1'b1, 1'b1, 5'd31}) begin n_err++; $display("FAIL jal_word got v%0h j%0h jj%0h w%0h d%0d want v1 j3 jj1 w1 d31", ex_valid, ex_Jump, ex_J_Jump, ex_RegWrite, ex_dest); end
    n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL jal_flush_e1 got %0h want 0", flush); end
    set_id(1'b1, 6'b000000, 6'b100000, 5'd1, 5'd2, 5'd4);
    tick();
    n_vec++; if ({flush, ex_valid, ex_dest} !== {2'b11, 5'd4}) begin n_err++; $display("FAIL jal_slot got f%0h v%0h d%0d want f1 v1 d4", flush, ex_valid, ex_dest); end
    tick();
    n_vec++; if ({flush, ex_valid} !== 2'b10) begin n_err++; $display("FAIL jal_bubble1 got f%0h v%0h want f1 v0", flush, ex_valid); end
    tick();
    n_vec++; if ({flush, ex_valid} !== 2'b00) begin n_err++; $display("FAIL jal_bubble2 got f%0h v%0h want f0 v0", flush, ex_valid); end
    tick();
    n_vec++; if ({ex_valid, ex_dest} !== {1'b1, 5'd4}) begin n_err++; $display("FAIL jal_resume got v%0h d%0d want v1 d4", ex_valid, ex_dest); end
    set_id(1'b1, 6'b000011, 6'b000000, 5'd0, 5'd0, 5'd0);
    tick();
    set_id(1'b1, 6'b000000, 6'b100000, 5'd1, 5'd2, 5'd4);
    tick();
    reset = 1'b1;
    tick();
    n_vec++; if ({flush, ex_valid, ex_RegWrite, ex_J_Jump, ex_dest} !== {4'b0000, 5'd0}) begin n_err++; $display("FAIL reset_mid_flush got %0h want 0", {flush, ex_valid, ex_RegWrite, ex_J_Jump, ex_dest}); end
    reset = 1'b0;
    tick();
    n_vec++; if ({flush, ex_valid, ex_dest} !== {2'b01, 5'd4}) begin n_err++; $display("FAIL run_after_reset got f%0h v%0h d%0d want f0 v1 d4", flush, ex_valid, ex_dest); end
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    reset = 1'b1;
    set_id(1'b0, 6'b000000, 6'b000000, 5'd0, 5'd0, 5'd0);
    tick();
    reset = 1'b0;
    n_vec++; if ({stall_count, flush_count} !== 64'd0) begin n_err++; $display("FAIL stats_reset got %0d/%0d want 0/0", stall_count, flush_count); end
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 6'b100011, 6'b000000, 5'd1, 5'd5, 5'd0);
      tick();
      set_id(1'b1, 6'b000000, 6'b100000, 5'd5, 5'd2, 5'd6);
      tick(); tick();
    end
    set_id(1'b0, 6'b000000, 6'b000000, 5'd0, 5'd0, 5'd0);
    branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    tick(); tick(); tick();
    n_vec++; if (stall_count !== 32'd3) begin n_err++; $display("FAIL stall_count got %0d want 3", stall_count); end
    n_vec++; if (flush_count !== 32'd2) begin n_err++; $display("FAIL flush_count got %0d want 2", flush_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_decode();
    test_load_use();
    test_jr_forward();
    test_branch_flush();
    test_jal_and_reset();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipelined_control.md
Name: pipelined_control

Overview:
- Registered successor to the combinational instruction decoder.
- Decodes the ID-stage instruction fields into the existing control word and registers it into the ID/EX pipeline register.
- Adds a load-use hazard stall, JR forwarding selection and branch-flush sequencing.
- Sits between the IF/ID register and the EX stage; the datapath honours the stall output by holding PC and IF/ID.

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- ALUOP_W, 4, ALUOp field width; encodings below occupy the low 4 bits, upper bits zero.
- FLUSH_CYCLES, 1, bubbles inserted after a taken branch or jump (1..7).
- LINK_REG, 31, destination register written by jal.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- id_valid  in  1  IF/ID holds a real instruction
- opcode  in  6  instruction[31:26]
- funct  in  6  instruction[5:0]
- rs  in  REG_ADDR_W  source register
- rt  in  REG_ADDR_W  second source / I-type destination
- rd  in  REG_ADDR_W  R-type destination
- branch_taken  in  1  EX-stage branch resolved taken
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- flush  out  1  IF/ID being squashed (registered state)
- ex_valid  out  1  ID/EX holds a real instruction
- ex_dest  out  REG_ADDR_W  resolved write register
- ex_RegWrite, ex_MemToReg, ex_MemRead, ex_MemWrite, ex_Branch, ex_RegDst, ex_ALUSrc, ex_J_Jump  out  1 each  registered control bits
- ex_ALUOp  out  ALUOP_W  ALU operation
- ex_Jump  out  2  00 none, 01 JR, 10 JR forwarded, 11 jal
- ex_Branch_op  out  3  001 beq, 010 bne, 011 bgtz, 100 bgez

Behaviour:
- Decode table is unchanged from the current decoder.
  - R-type ALUOp: add 0001, addu 1010, sub 0010, subu 1011, and 0011, or 0100, nor 0101, slt 0110, sll 0111, srl 1000, sra 1001.
  - jr: Jump=01 and no RegWrite.
  - I-type ops set ALUSrc, RegWrite and RegDst: andi, ori, slti, addi, addiu, lui=1111.
  - lw additionally sets MemRead and MemToReg.
  - sw: ALUSrc, MemWrite, ALUOp 0001.
  - Branches set Branch and Branch_op.
  - j sets J_Jump; jal sets J_Jump and Jump=11.
  - Unknown opcode or funct: all-zero control word.
- Destination: RegDst=1 selects rt; jal selects LINK_REG; otherwise rd. When RegWrite=0, ex_dest is 0.
- Reset: every ex_* output is 0, flush=0, and the FSM enters RUN. Reset asserted mid-stall or mid-flush aborts to RUN on the next edge.
- FSM states: RUN, FLUSH.
- Flush entry:
  - branch_taken in any state loads the counter with FLUSH_CYCLES and enters FLUSH.
  - In RUN, a decoded j or jal with id_valid does the same one cycle after it is latched into ID/EX.
- FLUSH state: flush=1, ID/EX is loaded with a bubble each cycle, and the counter decrements. Return to RUN when the counter reaches 1, unless a new branch_taken arrives, which reloads the counter.
- Load-use stall (combinational):
  - stall=1 when, in RUN, id_valid, ex_valid, ex_MemRead, ex_dest!=0, and ex_dest equals rs, or equals rt for an instruction that reads rt (R-type, beq, bne, sw).
  - During a stall, ID/EX gets a bubble and the IF/ID instruction is re-decoded on the next cycle.
  - Latency: exactly 1 bubble.
- JR forwarding: when decoding jr with ex_valid, ex_RegWrite, ex_MemRead=0 and ex_dest==rs (rs!=0), Jump=10 instead of 01.
- Priority: reset > branch_taken/FLUSH > stall > normal load.
- Bubble: ex_valid=0, all control bits 0, ex_dest=0. id_valid=0 also produces a bubble.
- Otherwise ID/EX loads the decoded word with a 1-cycle latency from ID inputs to ex_* outputs.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - Adds outputs stall_count[31:0] and flush_count[31:0], both cleared by reset.
  - stall_count increments on each cycle with stall=1; flush_count increments on each bubble cycle spent in FLUSH.
  - Both counters saturate at 32'hFFFFFFFF.
- Undefined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- add (op 000000, funct 100000, rd=3) with id_valid=1 -> next cycle ex_RegWrite=1, ex_ALUOp=0001, ex_dest=3, ex_valid=1, stall=0.
- lw rt=5, then add rs=5 -> stall=1 for one cycle, one bubble in ID/EX (ex_valid=0), then the add is latched with ex_dest=rd.
- addi rt=8, then jr rs=8 -> ex_Jump=10; jr rs=9 in the same situation -> ex_Jump=01.
- branch_taken pulse with FLUSH_CYCLES=2 -> flush=1 for 2 cycles, two bubbles, then RUN; a second branch_taken during FLUSH reloads to 2.
- jal -> ex_Jump=11, ex_J_Jump=1, ex_dest=31, followed by FLUSH_CYCLES bubbles; reset asserted during a flush -> all ex_* 0 and flush=0 on the next edge.
- With HAZARD_STATS_EN defined: 3 load-use stalls and one 2-cycle flush -> stall_count=3, flush_count=2.
